// File: rtl/bus_word_rx.sv
// Assembles two bus bytes (high first) into one instruction word and holds it
// in a single-entry output register behind a valid/ready handshake.
module bus_word_rx #(
   parameter int DW    = 8,
   parameter int OPC_W = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ena,
   input  logic [DW-1:0]         data,
   input  logic                  load,
   input  logic                  abort,
   input  logic                  word_ready,
   output logic                  word_valid,
   output logic [2*DW-1:0]       ir_word,
   output logic [OPC_W-1:0]      opcode,
   output logic [2*DW-OPC_W-1:0] ir_addr,
   output logic                  expect_lo,
   output logic                  overrun
);

   // state | meaning
   // HI    | awaiting the high byte
   // LO    | high byte staged, awaiting the low byte
   // FULL  | complete word held, waiting for the consumer
   typedef enum logic [1:0] {
      ST_HI   = 2'd0,
      ST_LO   = 2'd1,
      ST_FULL = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [DW-1:0]     hi_stage_q, hi_stage_d;
   logic [2*DW-1:0]   ir_word_q, ir_word_d;
   logic              overrun_q, overrun_d;
   logic              ld, ab;

   // ena gates the fetch controls only; the output handshake is always live
   assign ld = ena & load;
   assign ab = ena & abort;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_HI;
         hi_stage_q <= '0;
         ir_word_q  <= '0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         hi_stage_q <= hi_stage_d;
         ir_word_q  <= ir_word_d;
         overrun_q  <= overrun_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      hi_stage_d = hi_stage_q;
      ir_word_d  = ir_word_q;
      overrun_d  = overrun_q;
      unique case (state_q)
         ST_HI: begin
            if (!ab && ld) begin
               hi_stage_d = data;
               state_d    = ST_LO;
            end
         end
         ST_LO: begin
            if (ab) begin
               hi_stage_d = '0;
               state_d    = ST_HI;
            end else if (ld) begin
               ir_word_d = {hi_stage_q, data};
               state_d   = ST_FULL;
            end
         end
         ST_FULL: begin
            // A byte arriving in the transfer cycle becomes the next high byte
            if (word_ready) begin
               if (ld) begin
                  hi_stage_d = data;
                  state_d    = ST_LO;
               end else begin
                  state_d = ST_HI;
               end
            end else if (ld) begin
               overrun_d = 1'b1;
            end
         end
         default: state_d = ST_HI;
      endcase
   end

   assign word_valid = (state_q == ST_FULL);
   assign expect_lo  = (state_q == ST_LO);
   assign overrun    = overrun_q;
   assign ir_word    = ir_word_q;
   assign opcode     = ir_word_q[2*DW-1 -: OPC_W];
   assign ir_addr    = ir_word_q[2*DW-OPC_W-1:0];

endmodule

// File: tb/tb_bus_word_rx.sv
// Directed bench for bus_word_rx: drives one step per clock and checks the
// registered outputs shortly after each rising edge.
module tb_bus_word_rx;

   logic        clk = 1'b0;
   logic        rst, ena, load, abort, word_ready;
   logic [7:0]  data;
   logic        word_valid, expect_lo, overrun;
   logic [15:0] ir_word;
   logic [2:0]  opcode;
   logic [12:0] ir_addr;

   int tests = 0;
   int fails = 0;

   bus_word_rx #(.DW(8), .OPC_W(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .ena        (ena),
      .data       (data),
      .load       (load),
      .abort      (abort),
      .word_ready (word_ready),
      .word_valid (word_valid),
      .ir_word    (ir_word),
      .opcode     (opcode),
      .ir_addr    (ir_addr),
      .expect_lo  (expect_lo),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Apply inputs, clock once, and settle past the edge before checking.
   task automatic step(input logic ld, input logic [7:0] d, input logic ab, input logic rdy);
      load       = ld;
      data       = d;
      abort      = ab;
      word_ready = rdy;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; ena = 1'b1; load = 1'b0; abort = 1'b0; word_ready = 1'b0; data = 8'h00;
      #1;
      step(0, 8'h00, 0, 0);
      step(0, 8'h00, 0, 0);
      rst = 1'b0;
      chk("rst_word",   ir_word, 16'h0000);
      chk("rst_valid",  word_valid, 16'd0);
      chk("rst_explo",  expect_lo, 16'd0);
      chk("rst_ovr",    overrun, 16'd0);
      chk("rst_opc",    opcode, 16'd0);
      chk("rst_addr",   ir_addr, 16'd0);

      // basic fetch
      step(1, 8'hA5, 0, 0);
      chk("basic_explo", expect_lo, 16'd1);
      chk("basic_v0",    word_valid, 16'd0);
      step(1, 8'h3C, 0, 0);
      chk("basic_word",  ir_word, 16'hA53C);
      chk("basic_opc",   opcode, 16'd5);
      chk("basic_addr",  ir_addr, 16'h053C);
      chk("basic_v1",    word_valid, 16'd1);
      chk("basic_explo0", expect_lo, 16'd0);
      step(0, 8'h00, 0, 0);
      chk("basic_hold",  word_valid, 16'd1);
      step(0, 8'h00, 0, 1);
      chk("basic_xfer",  word_valid, 16'd0);
      chk("basic_keep",  ir_word, 16'hA53C);

      // abort
      step(1, 8'h12, 0, 0);
      chk("ab_explo",    expect_lo, 16'd1);
      step(1, 8'h34, 1, 0);
      chk("ab_explo0",   expect_lo, 16'd0);
      chk("ab_v0",       word_valid, 16'd0);
      step(1, 8'h56, 0, 0);
      chk("ab_v0b",      word_valid, 16'd0);
      step(1, 8'h78, 0, 0);
      chk("ab_word",     ir_word, 16'h5678);
      chk("ab_v1",       word_valid, 16'd1);
      step(0, 8'h00, 1, 0);
      chk("ab_full_keep", word_valid, 16'd1);
      step(0, 8'h00, 0, 1);
      chk("ab_xfer",     word_valid, 16'd0);

      // overrun
      step(1, 8'h11, 0, 0);
      step(1, 8'h11, 0, 0);
      chk("ov_word",     ir_word, 16'h1111);
      chk("ov_ovr0",     overrun, 16'd0);
      step(1, 8'h22, 0, 0);
      chk("ov_ovr1",     overrun, 16'd1);
      chk("ov_keep",     ir_word, 16'h1111);
      chk("ov_v1",       word_valid, 16'd1);
      step(0, 8'h00, 0, 1);
      chk("ov_xfer",     word_valid, 16'd0);
      chk("ov_sticky",   overrun, 16'd1);
      step(0, 8'h00, 0, 0);
      chk("ov_sticky2",  overrun, 16'd1);

      // back-to-back with ready tied high
      step(1, 8'h01, 0, 1);
      chk("bb_explo1",   expect_lo, 16'd1);
      step(1, 8'h02, 0, 1);
      chk("bb_w1",       ir_word, 16'h0102);
      chk("bb_v1",       word_valid, 16'd1);
      step(1, 8'h03, 0, 1);
      chk("bb_v1_off",   word_valid, 16'd0);
      chk("bb_explo3",   expect_lo, 16'd1);
      step(1, 8'h04, 0, 1);
      chk("bb_w2",       ir_word, 16'h0304);
      chk("bb_v2",       word_valid, 16'd1);
      step(0, 8'h00, 0, 1);
      chk("bb_v2_off",   word_valid, 16'd0);
      chk("bb_idle_lo",  expect_lo, 16'd0);

      // capture during the transfer cycle of a held word
      step(1, 8'h06, 0, 0);
      step(1, 8'h07, 0, 0);
      step(0, 8'h00, 0, 0);
      chk("tx_held",     ir_word, 16'h0607);
      step(1, 8'h05, 0, 1);
      chk("tx_v0",       word_valid, 16'd0);
      chk("tx_explo",    expect_lo, 16'd1);
      step(1, 8'h09, 0, 0);
      chk("tx_word",     ir_word, 16'h0509);
      chk("tx_v1",       word_valid, 16'd1);

      // ena low: handshake still completes, fetch controls ignored
      ena = 1'b0;
      step(1, 8'hEE, 0, 1);
      chk("en_xfer",     word_valid, 16'd0);
      chk("en_explo",    expect_lo, 16'd0);
      step(1, 8'hAA, 0, 0);
      chk("en_ign_lo",   expect_lo, 16'd0);
      chk("en_ign_v",    word_valid, 16'd0);
      chk("en_word",     ir_word, 16'h0509);
      ena = 1'b1;

      // reset with a high byte staged
      step(1, 8'hDD, 0, 0);
      chk("rs_staged",   expect_lo, 16'd1);
      rst = 1'b1;
      step(0, 8'h00, 0, 0);
      rst = 1'b0;
      chk("rs_explo",    expect_lo, 16'd0);
      chk("rs_word",     ir_word, 16'h0000);
      chk("rs_ovr",      overrun, 16'd0);
      chk("rs_valid",    word_valid, 16'd0);
      step(1, 8'hBB, 0, 0);
      ena = 1'b0;
      step(0, 8'h00, 1, 0);
      chk("rs_ena_hold", expect_lo, 16'd1);
      ena = 1'b1;
      step(1, 8'hCC, 0, 0);
      chk("rs_word2",    ir_word, 16'hBBCC);
      chk("rs_opc2",     opcode, 16'd5);
      chk("rs_addr2",    ir_addr, 16'h1BCC);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
